sm4_axis_pad_gen: RTL and testbench

//  Parametrised AXI-Stream block padder in front of the SM4 core. Extends each packet to a whole number
//  of BLOCK_BYTES cipher blocks. Supports DATA_BYTES-wide beats with tkeep and full output backpressure.

---
 rtl/sm4_axis_pad_gen_if.sv | 27 ++
 rtl/sm4_axis_pad_gen.sv | 183 ++++++++++++++++++
 tb/tb_sm4_axis_pad_gen.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sm4_axis_pad_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : sm4_axis_pad_gen_if
// Purpose  : AXI-Stream bundle used on both sides of the SM4 block padder.
//            The master modport drives data/valid/last/user/keep and
//            receives ready; the slave modport is the mirror image.
// Signals  : tdata  [8*DATA_BYTES]  byte lane 0 = tdata[7:0] = first byte
//            tkeep  [DATA_BYTES]    byte enables
//            tvalid, tlast, tready  standard AXI-Stream handshake/framing
//            tuser  [USER_WIDTH]    sideband
// Revision : 1.0  initial release
// ============================================================================
interface sm4_axis_pad_gen_if #(
   parameter int DATA_BYTES = 1,
   parameter int USER_WIDTH = 8
);
   logic [8*DATA_BYTES-1:0] tdata;
   logic [DATA_BYTES-1:0]   tkeep;
   logic                    tvalid;
   logic                    tlast;
   logic [USER_WIDTH-1:0]   tuser;
   logic                    tready;

   modport master (output tdata, tkeep, tvalid, tlast, tuser, input  tready);
   modport slave  (input  tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface
`default_nettype wire

// File: rtl/sm4_axis_pad_gen.sv
`default_nettype none
// ============================================================================
// Module   : sm4_axis_pad_gen
// Purpose  : AXI-Stream block padder in front of the SM4 core. Extends every
//            packet to a whole number of BLOCK_BYTES cipher blocks, emitting
//            only full beats with tlast on the final block beat. One output
//            register stage with full backpressure.
// Ports    : clk       clock
//            rst       synchronous reset, active high
//            pad_mode  0: zero pad, 1: PKCS#7 (sampled on first beat)
//            s_axis    slave stream  (tdata/tkeep/tvalid/tlast/tuser/tready)
//            m_axis    master stream (tkeep driven all-ones)
//            err       one-cycle pulse on an accepted malformed beat
// Config   : SM4_PAD_PKCS7_EN defined   -> pad_mode honoured
//            SM4_PAD_PKCS7_EN undefined -> zero padding only
// Revision : 1.0  initial release
// ============================================================================
module sm4_axis_pad_gen #(
   parameter int DATA_BYTES  = 1,
   parameter int BLOCK_BYTES = 16,
   parameter int USER_WIDTH  = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pad_mode,
   sm4_axis_pad_gen_if.slave  s_axis,
   sm4_axis_pad_gen_if.master m_axis,
   output logic               err
);
   localparam int c_BEATS = BLOCK_BYTES / DATA_BYTES;
   localparam int c_CW    = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
   localparam logic [c_CW-1:0]       c_LAST_CNT = c_CW'(c_BEATS - 1);
   localparam logic [DATA_BYTES-1:0] c_KEEP_ALL = '1;

   localparam logic [0:0] c_ST_PASS = 1'b0;
   localparam logic [0:0] c_ST_PAD  = 1'b1;

   logic [0:0]              r_state, w_state_nxt;
   logic [c_CW-1:0]         r_beat_cnt;
   logic [8*DATA_BYTES-1:0] r_tdata, w_nxt_tdata;
   logic                    r_tvalid, r_tlast, w_nxt_tlast;
   logic [USER_WIDTH-1:0]   r_tuser, w_nxt_tuser;
   logic                    r_err;
   logic [7:0]              r_pad_byte;
   logic [USER_WIDTH-1:0]   r_pad_user;

   logic                    w_load, w_acc, w_fire, w_last_cnt;
   logic                    w_contig, w_viol, w_pkcs;
   logic [DATA_BYTES-1:0]   w_keep;
   logic [7:0]              w_pad_byte;

   assign w_load        = !r_tvalid || m_axis.tready;
   assign s_axis.tready = (r_state == c_ST_PASS) && w_load;
   assign w_acc         = s_axis.tvalid && s_axis.tready;
   assign w_last_cnt    = (r_beat_cnt == c_LAST_CNT);

   // A contiguous-from-lane-0 mask has the form 0..01..1, so adding one
   // carries through every set bit and leaves no overlap with the original.
   assign w_contig = ((s_axis.tkeep & (s_axis.tkeep + DATA_BYTES'(1))) == '0);
   assign w_viol   = (s_axis.tkeep == '0) || !w_contig ||
                     (!s_axis.tlast && (s_axis.tkeep != c_KEEP_ALL));
   assign w_keep   = w_viol ? c_KEEP_ALL : s_axis.tkeep;

`ifdef SM4_PAD_PKCS7_EN
   logic        r_mode, r_in_pkt;
   logic [7:0]  w_n;
   logic [15:0] w_off;
   logic [7:0]  w_rem;

   always_comb begin
      w_n = '0;
      for (int i = 0; i < DATA_BYTES; i++) begin
         w_n = w_n + 8'(w_keep[i]);
      end
      w_off = 16'(r_beat_cnt) * 16'(DATA_BYTES) + 16'(w_n);
      // off never exceeds BLOCK_BYTES, so the modulo reduces to one compare
      w_rem = (w_off >= 16'(BLOCK_BYTES)) ? 8'd0 : 8'(16'(BLOCK_BYTES) - w_off);
   end

   // mode of the current packet: live input on its first beat, latched after
   assign w_pkcs     = r_in_pkt ? r_mode : pad_mode;
   assign w_pad_byte = w_pkcs ? ((w_rem == 8'd0) ? 8'(BLOCK_BYTES) : w_rem) : 8'h00;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mode   <= 1'b0;
         r_in_pkt <= 1'b0;
      end else if (w_acc) begin
         if (!r_in_pkt) r_mode <= pad_mode;
         r_in_pkt <= !s_axis.tlast;
      end
   end
`else
   logic w_unused_mode;
   assign w_unused_mode = pad_mode;
   assign w_pkcs        = 1'b0;
   assign w_pad_byte    = 8'h00;
`endif

   // next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_PASS: begin
            if (w_acc && s_axis.tlast && (w_pkcs || !w_last_cnt)) w_state_nxt = c_ST_PAD;
         end
         c_ST_PAD: begin
            if (w_load && w_last_cnt) w_state_nxt = c_ST_PASS;
         end
         default: w_state_nxt = c_ST_PASS;
      endcase
   end

   // output-register next values
   always_comb begin
      w_fire      = 1'b0;
      w_nxt_tdata = r_tdata;
      w_nxt_tlast = r_tlast;
      w_nxt_tuser = r_tuser;
      case (r_state)
         c_ST_PASS: begin
            if (w_acc) begin
               w_fire = 1'b1;
               for (int i = 0; i < DATA_BYTES; i++) begin
                  w_nxt_tdata[8*i +: 8] = (s_axis.tlast && !w_keep[i]) ? w_pad_byte
                                                                        : s_axis.tdata[8*i +: 8];
               end
               w_nxt_tlast = s_axis.tlast && !w_pkcs && w_last_cnt;
               w_nxt_tuser = s_axis.tuser;
            end
         end
         c_ST_PAD: begin
            if (w_load) begin
               w_fire      = 1'b1;
               w_nxt_tdata = {DATA_BYTES{r_pad_byte}};
               w_nxt_tlast = w_last_cnt;
               w_nxt_tuser = r_pad_user;
            end
         end
         default: ;
      endcase
   end

   // state and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= c_ST_PASS;
         r_beat_cnt <= '0;
         r_tdata    <= '0;
         r_tvalid   <= 1'b0;
         r_tlast    <= 1'b0;
         r_tuser    <= '0;
         r_err      <= 1'b0;
         r_pad_byte <= 8'h00;
         r_pad_user <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_err   <= w_acc && w_viol;
         if (w_load) begin
            r_tvalid <= w_fire;
            r_tdata  <= w_nxt_tdata;
            r_tlast  <= w_nxt_tlast;
            r_tuser  <= w_nxt_tuser;
         end
         if (w_fire) begin
            r_beat_cnt <= (w_nxt_tlast || w_last_cnt) ? '0 : r_beat_cnt + 1'b1;
         end
         if (w_acc && s_axis.tlast) begin
            r_pad_byte <= w_pad_byte;
            r_pad_user <= s_axis.tuser;
         end
      end
   end

   assign m_axis.tdata  = r_tdata;
   assign m_axis.tkeep  = c_KEEP_ALL;
   assign m_axis.tvalid = r_tvalid;
   assign m_axis.tlast  = r_tlast;
   assign m_axis.tuser  = r_tuser;
   assign err           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sm4_axis_pad_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_sm4_axis_pad_gen
// Purpose  : Self-checking bench for sm4_axis_pad_gen (DATA_BYTES=4,
//            BLOCK_BYTES=16). Expected output beats are generated from a
//            reference model when each input beat is driven and compared
//            in order as the DUT emits them.
// Revision : 1.0  initial release
// ============================================================================
module tb_sm4_axis_pad_gen;
   localparam int DB = 4;
   localparam int BB = 16;
   localparam int UW = 8;
   localparam int NB = BB / DB;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic pad_mode = 1'b0;
   logic err;

   sm4_axis_pad_gen_if #(.DATA_BYTES(DB), .USER_WIDTH(UW)) s_if ();
   sm4_axis_pad_gen_if #(.DATA_BYTES(DB), .USER_WIDTH(UW)) m_if ();

   sm4_axis_pad_gen #(.DATA_BYTES(DB), .BLOCK_BYTES(BB), .USER_WIDTH(UW)) dut (
      .clk      (clk),
      .rst      (rst),
      .pad_mode (pad_mode),
      .s_axis   (s_if),
      .m_axis   (m_if),
      .err      (err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [8*DB-1:0] d;
      logic            l;
      logic [UW-1:0]   u;
   } beat_t;

   beat_t exp_q[$];
   beat_t e_beat;
   int    n_total  = 0;
   int    n_bad    = 0;
   int    exp_err  = 0;
   int    err_seen = 0;
   int    m_cnt    = 0;
   bit    mon_en   = 1'b0;
   bit    rdy_rand = 1'b0;
   logic  rdy_val  = 1'b1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic bit eff_mode(input bit m);
`ifdef SM4_PAD_PKCS7_EN
      return m;
`else
      return m & 1'b0;
`endif
   endfunction

   // Reference model: expand one input beat into the expected output beats.
   task automatic model_beat(input logic [31:0] d, input logic [3:0] k, input logic [7:0] u,
                             input bit last, input bit mode);
      bit          bad, seen0, lp;
      int          n, off, rem;
      logic [7:0]  pb;
      logic [31:0] od;
      bad = (k == 4'h0);
      seen0 = 1'b0;
      n = 0;
      for (int i = 0; i < DB; i++) begin
         if (!k[i]) seen0 = 1'b1;
         else begin
            if (seen0) bad = 1'b1;
            n++;
         end
      end
      if (!last && k != 4'hF) bad = 1'b1;
      if (bad) begin
         exp_err++;
         n = DB;
      end
      if (!last) begin
         exp_q.push_back(beat_t'{d: d, l: 1'b0, u: u});
         m_cnt = (m_cnt + 1) % NB;
         return;
      end
      off = m_cnt * DB + n;
      rem = (BB - off) % BB;
      pb  = mode ? ((rem == 0) ? 8'(BB) : 8'(rem)) : 8'h00;
      od  = d;
      for (int i = n; i < DB; i++) od[8*i +: 8] = pb;
      if (!mode && m_cnt == NB - 1) begin
         exp_q.push_back(beat_t'{d: od, l: 1'b1, u: u});
         m_cnt = 0;
         return;
      end
      exp_q.push_back(beat_t'{d: od, l: 1'b0, u: u});
      m_cnt = (m_cnt + 1) % NB;
      lp = 1'b0;
      while (!lp) begin
         lp = (m_cnt == NB - 1);
         exp_q.push_back(beat_t'{d: {DB{pb}}, l: lp, u: u});
         m_cnt = lp ? 0 : m_cnt + 1;
      end
   endtask

   // Called at a negedge; returns at the negedge after the beat is accepted.
   task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic [7:0] u,
                            input bit last, input bit mode, input bit pm);
      int w;
      model_beat(d, k, u, last, mode);
      s_if.tdata  = d;
      s_if.tkeep  = k;
      s_if.tuser  = u;
      s_if.tlast  = last;
      s_if.tvalid = 1'b1;
      pad_mode    = pm;
      w = 0;
      while (s_if.tready !== 1'b1 && w < 500) begin
         @(negedge clk);
         w++;
      end
      if (w >= 500) check("s_tready_timeout", 64'(w), 64'(0));
      @(negedge clk);
      s_if.tvalid = 1'b0;
   endtask

   // pad_mode is flipped after the first beat; it must not affect the packet.
   task automatic send_pkt(input int len, input bit mode, input logic [7:0] u0, input bit rnd);
      int nbeats;
      nbeats = (len + DB - 1) / DB;
      for (int b = 0; b < nbeats; b++) begin
         logic [31:0] d;
         logic [3:0]  k;
         int          nb;
         nb = (b == nbeats - 1) ? len - b * DB : DB;
         for (int i = 0; i < DB; i++) d[8*i +: 8] = rnd ? 8'($urandom) : 8'(b * DB + i);
         k = 4'((1 << nb) - 1);
         send_beat(d, k, 8'(u0 + 8'(b)), (b == nbeats - 1), eff_mode(mode),
                   (b == 0) ? mode : !mode);
      end
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (exp_q.size() != 0 && w < 3000) begin
         @(negedge clk);
         w++;
      end
      if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'(0));
      repeat (2) @(negedge clk);
   endtask

   // output ready driver, updated just after the active edge
   initial begin
      m_if.tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_if.tready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
      end
   end

   // output monitor
   always @(negedge clk) begin
      if (mon_en) begin
         if (err === 1'b1) err_seen++;
         if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", 64'(m_if.tdata), 64'(0));
            end else begin
               e_beat = exp_q.pop_front();
               check("tdata", 64'(m_if.tdata), 64'(e_beat.d));
               check("tlast", 64'(m_if.tlast), 64'(e_beat.l));
               check("tuser", 64'(m_if.tuser), 64'(e_beat.u));
            end
         end
      end
   end

   initial begin
      s_if.tvalid = 1'b0;
      s_if.tdata  = '0;
      s_if.tkeep  = '0;
      s_if.tlast  = 1'b0;
      s_if.tuser  = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_tvalid", 64'(m_if.tvalid), 64'(0));
      check("rst_tlast",  64'(m_if.tlast),  64'(0));
      check("rst_tdata",  64'(m_if.tdata),  64'(0));
      check("rst_tuser",  64'(m_if.tuser),  64'(0));
      check("rst_err",    64'(err),         64'(0));
      rst = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);

      // directed packets with output always ready
      send_pkt(16, 1'b0, 8'h10, 1'b0);
      send_pkt(13, 1'b0, 8'h20, 1'b0);
      send_pkt(5,  1'b0, 8'h30, 1'b0);
      send_pkt(5,  1'b1, 8'h40, 1'b0);
      send_pkt(16, 1'b1, 8'h50, 1'b0);
      send_pkt(3,  1'b1, 8'h58, 1'b0);

      // malformed keep on a non-last beat, then a well-formed last beat
      send_beat(32'hA3A2A1A0, 4'b0101, 8'h60, 1'b0, eff_mode(1'b0), 1'b0);
      send_beat(32'hB3B2B1B0, 4'b0011, 8'h61, 1'b1, eff_mode(1'b0), 1'b0);
      drain();
      check("err_directed", 64'(err_seen), 64'(exp_err));

      // random backpressure with back-to-back random packets
      rdy_rand = 1'b1;
      for (int p = 0; p < 30; p++) begin
         send_pkt($urandom_range(1, 40), 1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
      end
      drain();
      rdy_rand = 1'b0;
      rdy_val  = 1'b0;
      repeat (2) @(negedge clk);

      // reset while stalled in the pad phase
      send_pkt(1, 1'b0, 8'h70, 1'b0);
      repeat (3) @(negedge clk);
      check("pad_hold_tvalid", 64'(m_if.tvalid), 64'(1));
      mon_en = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_pad_tvalid", 64'(m_if.tvalid), 64'(0));
      rst = 1'b0;
      exp_q.delete();
      m_cnt   = 0;
      rdy_val = 1'b1;
      mon_en  = 1'b1;
      @(negedge clk);
      send_pkt(6, 1'b1, 8'h80, 1'b0);
      drain();

      check("err_total", 64'(err_seen), 64'(exp_err));
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
